// File: rtl/synchronizer_multi.sv
// synchronizer_multi: N-channel input synchronizer with a per-channel deglitch filter.
// Each asynchronous input bit passes through a STAGES-deep flop chain. The filtered
// output only follows the synchronized level after it has held for FILTER_CNT cycles.
// FILTER_CNT = 0 bypasses the filter.
// Optional feature macro: SYNC_EDGE_EN adds the y_rise / y_fall one-cycle edge pulses.

module synchronizer_multi #(
    parameter int   WIDTH      = 1,
    parameter int   STAGES     = 2,
    parameter int   FILTER_CNT = 4,
    parameter logic RESET_VAL  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    output logic [WIDTH-1:0] y_out
`ifdef SYNC_EDGE_EN
    ,
    output logic [WIDTH-1:0] y_rise,
    output logic [WIDTH-1:0] y_fall
`endif
);

    // A chain shorter than two flops gives no metastability protection, so refuse to build it.
    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("synchronizer_multi: STAGES must be at least 2");
        end
        if (WIDTH < 1) begin : g_bad_width
            $error("synchronizer_multi: WIDTH must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] sr [STAGES];
    logic [WIDTH-1:0] s;

    // Synchronizer chain: all channels shift in parallel, and reset loads the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sr[i] <= {WIDTH{RESET_VAL}};
            end
        end else begin
            sr[0] <= a_in;
            for (int i = 1; i < STAGES; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign s = sr[STAGES-1];

    generate
        if (FILTER_CNT == 0) begin : g_bypass
            assign y_out = s;
        end else begin : g_filter
            localparam int             CW       = $clog2(FILTER_CNT + 1);
            localparam logic [CW-1:0]  CNT_LAST = CW'(FILTER_CNT - 1);

            logic [CW-1:0]    cnt [WIDTH];
            logic [WIDTH-1:0] y_q;

            // Deglitch filter. A channel's counter runs only while its synchronized level
            // differs from its output. Any return to the output level cancels the count.
            // On the last count the output takes the new level, so the counter never wraps.
            always_ff @(posedge clk) begin
                if (rst) begin
                    y_q <= {WIDTH{RESET_VAL}};
                    for (int c = 0; c < WIDTH; c++) begin
                        cnt[c] <= '0;
                    end
                end else begin
                    for (int c = 0; c < WIDTH; c++) begin
                        if (s[c] == y_q[c]) begin
                            cnt[c] <= '0;
                        end else if (cnt[c] == CNT_LAST) begin
                            y_q[c] <= s[c];
                            cnt[c] <= '0;
                        end else begin
                            cnt[c] <= cnt[c] + CW'(1);
                        end
                    end
                end
            end

            assign y_out = y_q;
        end
    endgenerate

`ifdef SYNC_EDGE_EN
    logic [WIDTH-1:0] y_d;

    // Delayed copy of the output for edge detection. Reset loads the same level as
    // y_out, so reset and its release never produce a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_d <= {WIDTH{RESET_VAL}};
        end else begin
            y_d <= y_out;
        end
    end

    assign y_rise = y_out & ~y_d;
    assign y_fall = ~y_out & y_d;
`endif

endmodule

// File: tb/tb_synchronizer_multi.sv
// tb_synchronizer_multi: scoreboard bench for synchronizer_multi.
// dut_a uses a filter (WIDTH=4, STAGES=2, FILTER_CNT=4).
// dut_b uses bypass mode (WIDTH=4, STAGES=3, FILTER_CNT=0).
// Stimulus pushes each expected output transition, with the edge number on which it
// must appear. A separate monitor pops an entry every time an output bit changes.

module tb_synchronizer_multi;

    // Edges from the edge that first samples a new input until y_out changes, not counting that edge.
    // dut_a: STAGES + FILTER_CNT - 1 = 2 + 4 - 1 = 5.
    // dut_b: STAGES - 1 = 3 - 1 = 2.
    localparam int LAT_A = 5;
    localparam int LAT_B = 2;

    typedef struct {
        int   inst;
        int   ch;
        int   edge_no;
        logic val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] a_in_a, a_in_b;
    logic [3:0] y_out_a, y_out_b;
`ifdef SYNC_EDGE_EN
    logic [3:0] y_rise_a, y_fall_a, y_rise_b, y_fall_b;
`endif

    exp_t sb[$];
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;
    logic [3:0] prev_a, prev_b;

    synchronizer_multi #(.WIDTH(4), .STAGES(2), .FILTER_CNT(4), .RESET_VAL(1'b1)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .a_in   (a_in_a),
        .y_out  (y_out_a)
`ifdef SYNC_EDGE_EN
        ,
        .y_rise (y_rise_a),
        .y_fall (y_fall_a)
`endif
    );

    synchronizer_multi #(.WIDTH(4), .STAGES(3), .FILTER_CNT(0), .RESET_VAL(1'b1)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .a_in   (a_in_b),
        .y_out  (y_out_b)
`ifdef SYNC_EDGE_EN
        ,
        .y_rise (y_rise_b),
        .y_fall (y_fall_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one channel. When a transition is expected, queue the edge on which it must appear.
    task automatic applyStimulus(input int inst, input int ch, input logic val, input bit expect_change);
        if (inst == 0) a_in_a[ch] = val;
        else           a_in_b[ch] = val;
        if (expect_change)
            sb.push_back('{inst, ch, cyc + 1 + ((inst == 0) ? LAT_A : LAT_B), val});
    endtask

    task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    endtask

    // Match an observed transition against the oldest queued expectation for that channel.
    task automatic checkChange(input int inst, input int ch, input logic val);
        int idx;
        idx = -1;
        for (int i = 0; i < sb.size(); i++)
            if (idx < 0 && sb[i].inst == inst && sb[i].ch == ch) idx = i;
        total++;
        if (idx < 0) begin
            $display("[TB] FAIL unexpected_change dut%0d ch%0d: got %b at edge %0d, required no change",
                     inst, ch, val, cyc);
        end else begin
            if (sb[idx].edge_no == cyc && sb[idx].val === val) passed++;
            else $display("[TB] FAIL transition dut%0d ch%0d: got %b at edge %0d, required %b at edge %0d",
                          inst, ch, val, cyc, sb[idx].val, sb[idx].edge_no);
            sb.delete(idx);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge and checks every output bit that changed.
    initial begin
        prev_a = 4'hF;
        prev_b = 4'hF;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
`ifdef SYNC_EDGE_EN
                checkOutput("reset_pulses_a", y_rise_a | y_fall_a, 4'h0);
                checkOutput("reset_pulses_b", y_rise_b | y_fall_b, 4'h0);
`endif
            end else begin
                for (int ch = 0; ch < 4; ch++) begin
                    if (y_out_a[ch] !== prev_a[ch]) checkChange(0, ch, y_out_a[ch]);
                    if (y_out_b[ch] !== prev_b[ch]) checkChange(1, ch, y_out_b[ch]);
                end
`ifdef SYNC_EDGE_EN
                checkOutput("rise_a", y_rise_a, y_out_a & ~prev_a);
                checkOutput("fall_a", y_fall_a, ~y_out_a & prev_a);
                checkOutput("rise_b", y_rise_b, y_out_b & ~prev_b);
                checkOutput("fall_b", y_fall_b, ~y_out_b & prev_b);
`endif
            end
            prev_a = y_out_a;
            prev_b = y_out_b;
        end
    end

    initial begin
        rst    = 1'b1;
        a_in_a = 4'h0;
        a_in_b = 4'h0;

        // Reset held for 3 edges with every input low: all outputs must be idle-high.
        waitEdges(3);
        checkOutput("reset_a", y_out_a, 4'hF);
        checkOutput("reset_b", y_out_b, 4'hF);
        a_in_a = 4'hF;
        a_in_b = 4'hF;
        waitEdges(1);
        rst = 1'b0;
        waitEdges(4);
        checkOutput("post_release_a", y_out_a, 4'hF);
        checkOutput("post_release_b", y_out_b, 4'hF);

        // Latency: channel 0 falls exactly 5 edges after the edge that samples the new level.
        applyStimulus(0, 0, 1'b0, 1'b1);
        waitEdges(8);

        // Glitch reject: 3 low cycles are never qualified. A later real step still needs the full count.
        applyStimulus(0, 1, 1'b0, 1'b0);
        waitEdges(3);
        applyStimulus(0, 1, 1'b1, 1'b0);
        waitEdges(8);
        checkOutput("glitch_hold_a", y_out_a, 4'hE);
        applyStimulus(0, 1, 1'b0, 1'b1);
        waitEdges(8);

        // Bounce: low 2 cycles, high 1, then low. A single fall is timed from the last low run.
        applyStimulus(0, 2, 1'b0, 1'b0);
        waitEdges(2);
        applyStimulus(0, 2, 1'b1, 1'b0);
        waitEdges(1);
        applyStimulus(0, 2, 1'b0, 1'b1);
        waitEdges(10);
        checkOutput("bounce_settled_a", y_out_a, 4'h8);

        // Return channels 0..2 high together: three independent rises on the same edge.
        applyStimulus(0, 0, 1'b1, 1'b1);
        applyStimulus(0, 1, 1'b1, 1'b1);
        applyStimulus(0, 2, 1'b1, 1'b1);
        waitEdges(8);

        // An input toggling every cycle never qualifies.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, logic'(i % 2), 1'b0);
            waitEdges(1);
        end
        waitEdges(6);
        checkOutput("toggle_hold_a", y_out_a, 4'hF);

        // Mid-operation reset while the channel 3 counter is at 3. Counting restarts after release.
        applyStimulus(0, 3, 1'b0, 1'b0);
        waitEdges(5);
        rst = 1'b1;
        waitEdges(1);
        checkOutput("midop_reset_a", y_out_a, 4'hF);
        checkOutput("midop_reset_b", y_out_b, 4'hF);
        rst = 1'b0;
        applyStimulus(0, 3, 1'b0, 1'b1);
        waitEdges(8);
        applyStimulus(0, 3, 1'b1, 1'b1);
        waitEdges(8);

        // Bypass: the step follows after exactly 3 edges. A one-cycle glitch passes straight through.
        applyStimulus(1, 3, 1'b0, 1'b1);
        waitEdges(4);
        applyStimulus(1, 3, 1'b1, 1'b1);
        waitEdges(4);
        applyStimulus(1, 0, 1'b0, 1'b1);
        waitEdges(1);
        applyStimulus(1, 0, 1'b1, 1'b1);
        waitEdges(5);
        checkOutput("bypass_final_b", y_out_b, 4'hF);

        // Every queued transition must have been seen.
        waitEdges(3);
        total++;
        if (sb.size() == 0) passed++;
        else $display("[TB] FAIL missing_transition: got %0d unobserved, required 0 (first dut%0d ch%0d edge %0d)",
                      sb.size(), sb[0].inst, sb[0].ch, sb[0].edge_no);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
